// File: rtl/tc_pkg.sv
// Shared constants and elaboration helpers for the tc_counter_reg family.
package tc_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Effective modulus: MOD==0 selects the natural 2^W range.
    function automatic longint eff_mod(input int w, input int mod);
        return (mod == 0) ? (longint'(1) << w) : longint'(mod);
    endfunction

    function automatic bit cfg_ok(input int w, input int mod, input int step,
                                  input int sat, input int rst_val);
        longint m;
        if (w < 1 || w > 32) return 1'b0;
        if (mod < 0 || longint'(mod) > (longint'(1) << w)) return 1'b0;
        m = eff_mod(w, mod);
        if (step < 1 || longint'(step) >= m) return 1'b0;
        if (rst_val < 0 || longint'(rst_val) >= m) return 1'b0;
        if (sat != MODE_WRAP && sat != MODE_SAT) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/tc_counter_reg_if.sv
// Control/data bundle of the counter-register: load/count controls in, count and flags out.
interface tc_counter_reg_if #(
    parameter int W = 8
);
    logic         CLR;
    logic         LD;
    logic         EN;
    logic         UP;
    logic [W-1:0] D;
    logic [W-1:0] Q;
    logic         TC;
    logic         OVF;

    modport master (output CLR, LD, EN, UP, D, input Q, TC, OVF);
    modport slave  (input CLR, LD, EN, UP, D, output Q, TC, OVF);

endinterface

// File: rtl/tc_addsub.sv
// N-bit ripple adder/subtractor; subtract inverts B and injects a carry-in of 1.
module tc_addsub #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] s,
    output logic         co
);

    logic c;
    logic bx;

    // co is the carry out; when subtracting it is 1 exactly when a >= b.
    always_comb begin
        s  = '0;
        c  = sub;
        bx = 1'b0;
        for (int i = 0; i < N; i++) begin
            bx   = b[i] ^ sub;
            s[i] = a[i] ^ bx ^ c;
            c    = (a[i] & bx) | (c & (a[i] ^ bx));
        end
        co = c;
    end

endmodule

// File: rtl/tc_counter_reg.sv
// Loadable up/down modulo counter-register with wrap/saturate modes, terminal count and overflow pulse.
module tc_counter_reg
    import tc_pkg::*;
#(
    parameter int W       = 8,
    parameter int MOD     = 0,
    parameter int STEP    = 1,
    parameter int SAT     = 0,
    parameter int RST_VAL = 0
) (
    input  logic              C,
    input  logic              R,
    tc_counter_reg_if.slave   bus
);

    if (!cfg_ok(W, MOD, STEP, SAT, RST_VAL)) begin : g_cfg_err
        $error("tc_counter_reg: illegal parameter set");
    end

    localparam logic [W:0]   M_V     = (W+1)'(eff_mod(W, MOD));
    localparam logic [W:0]   MAXV_X  = M_V - 1'b1;
    localparam logic [W-1:0] MAXV    = MAXV_X[W-1:0];
    localparam logic [W-1:0] M_LO    = M_V[W-1:0];
    localparam logic [W:0]   STEP_X  = (W+1)'(STEP);
    localparam logic [W-1:0] RST_V   = W'(RST_VAL);
    localparam bit           SAT_ON  = (SAT == MODE_SAT);

    logic [W-1:0] q_q, q_d;
    logic         ovf_q, ovf_d;
    logic [W:0]   res;
    logic         co;

    tc_addsub #(.N(W+1)) u_addsub (
        .a   ({1'b0, q_q}),
        .b   (STEP_X),
        .sub (~bus.UP),
        .s   (res),
        .co  (co)
    );

    // Wrap corrections use W-bit modular arithmetic: the true result is in range,
    // so dropping the top bit of M loses nothing (and covers MOD==0 where M_LO==0).
    always_comb begin
        q_d   = q_q;
        ovf_d = 1'b0;
        if (bus.CLR) begin
            q_d = '0;
        end else if (bus.LD) begin
            q_d = ({1'b0, bus.D} > MAXV_X) ? MAXV : bus.D;
        end else if (bus.EN) begin
            if (bus.UP) begin
                if (res > MAXV_X) begin
                    ovf_d = 1'b1;
                    q_d   = SAT_ON ? MAXV : (res[W-1:0] - M_LO);
                end else begin
                    q_d = res[W-1:0];
                end
            end else begin
                if (!co) begin
                    ovf_d = 1'b1;
                    q_d   = SAT_ON ? '0 : (res[W-1:0] + M_LO);
                end else begin
                    q_d = res[W-1:0];
                end
            end
        end
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            q_q   <= RST_V;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.Q   = q_q;
    assign bus.OVF = ovf_q;
    assign bus.TC  = bus.UP ? (q_q == MAXV) : (q_q == '0);

endmodule

// File: tb/tb_tc_counter_reg.sv
// Directed table-driven bench for tc_counter_reg in a mod-10 wrap and a mod-16 saturating configuration.
module tb_tc_counter_reg;

    typedef struct {
        logic       clr;
        logic       ld;
        logic       en;
        logic       up;
        logic [3:0] d;
        logic [3:0] q;
        logic       ovf;
        logic       tc;
    } vec_t;

    logic C;
    logic ra, rb;
    int   checks = 0;
    int   errors = 0;

    tc_counter_reg_if #(.W(4)) ifa ();
    tc_counter_reg_if #(.W(4)) ifb ();

    tc_counter_reg #(.W(4), .MOD(10), .STEP(1), .SAT(0), .RST_VAL(3)) u_a (
        .C   (C),
        .R   (ra),
        .bus (ifa.slave)
    );

    tc_counter_reg #(.W(4), .MOD(0), .STEP(3), .SAT(1), .RST_VAL(0)) u_b (
        .C   (C),
        .R   (rb),
        .bus (ifb.slave)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic clr, input logic ld, input logic en, input logic up,
                                input logic [3:0] d, input logic [3:0] q, input logic ovf,
                                input logic tc);
        vec_t v;
        v.clr = clr; v.ld = ld; v.en = en; v.up = up;
        v.d = d; v.q = q; v.ovf = ovf; v.tc = tc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic drive_a(input vec_t v);
        ifa.CLR = v.clr; ifa.LD = v.ld; ifa.EN = v.en; ifa.UP = v.up; ifa.D = v.d;
    endtask

    task automatic drive_b(input vec_t v);
        ifb.CLR = v.clr; ifb.LD = v.ld; ifb.EN = v.en; ifb.UP = v.up; ifb.D = v.d;
    endtask

    task automatic run_a(input vec_t v, input string nm);
        drive_a(v);
        @(posedge C); #1;
        chk({nm, ".Q"},   32'(ifa.Q),   32'(v.q));
        chk({nm, ".OVF"}, 32'(ifa.OVF), 32'(v.ovf));
        chk({nm, ".TC"},  32'(ifa.TC),  32'(v.tc));
    endtask

    task automatic run_b(input vec_t v, input string nm);
        drive_b(v);
        @(posedge C); #1;
        chk({nm, ".Q"},   32'(ifb.Q),   32'(v.q));
        chk({nm, ".OVF"}, 32'(ifb.OVF), 32'(v.ovf));
        chk({nm, ".TC"},  32'(ifb.TC),  32'(v.tc));
    endtask

    vec_t ta [20];
    vec_t tb [9];
    vec_t idle;

    initial begin
        //          clr   ld    en    up    d      q      ovf   tc
        ta[0]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd4,  1'b0, 1'b0);
        ta[1]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd5,  1'b0, 1'b0);
        ta[2]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd6,  1'b0, 1'b0);
        ta[3]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd7,  1'b0, 1'b0);
        ta[4]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd8,  1'b0, 1'b0);
        ta[5]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd9,  1'b0, 1'b1);
        ta[6]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd0,  1'b1, 1'b0);
        ta[7]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd1,  1'b0, 1'b0);
        ta[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  1'b0, 1'b1);
        ta[9]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd9,  1'b1, 1'b0);
        ta[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd8,  1'b0, 1'b0);
        ta[11] = mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 4'd9,  1'b0, 1'b1);
        ta[12] = mk(1'b1, 1'b1, 1'b1, 1'b1, 4'd5,  4'd0,  1'b0, 1'b0);
        ta[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b1);
        ta[14] = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  4'd0,  1'b0, 1'b0);
        ta[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b1);
        ta[16] = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  4'd0,  1'b0, 1'b0);
        ta[17] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b1);
        ta[18] = mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd5,  4'd5,  1'b0, 1'b0);
        ta[19] = mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd6,  1'b0, 1'b0);

        tb[0]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd14, 4'd14, 1'b0, 1'b0);
        tb[1]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd15, 1'b1, 1'b1);
        tb[2]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd15, 1'b1, 1'b1);
        tb[3]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd2,  4'd2,  1'b0, 1'b0);
        tb[4]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  1'b1, 1'b1);
        tb[5]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  1'b1, 1'b1);
        tb[6]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd3,  1'b0, 1'b0);
        tb[7]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd6,  1'b0, 1'b0);
        tb[8]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd15, 4'd15, 1'b0, 1'b1);

        idle = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
        drive_a(idle);
        drive_b(idle);
        ra = 1'b0;
        rb = 1'b0;

        // Reset state; clock edges during reset must not move Q.
        repeat (2) @(posedge C);
        #1;
        chk("A.rst.Q",   32'(ifa.Q),   32'd3);
        chk("A.rst.OVF", 32'(ifa.OVF), 32'd0);
        chk("A.rst.TC",  32'(ifa.TC),  32'd0);
        chk("B.rst.Q",   32'(ifb.Q),   32'd0);
        chk("B.rst.OVF", 32'(ifb.OVF), 32'd0);

        @(negedge C);
        ra = 1'b1;
        for (int i = 0; i < 20; i++) run_a(ta[i], $sformatf("A[%0d]", i));

        // Asynchronous reset between edges while counting from 6.
        #2;
        ra = 1'b0;
        #1;
        chk("A.async.Q",   32'(ifa.Q),   32'd3);
        chk("A.async.OVF", 32'(ifa.OVF), 32'd0);
        @(posedge C); #1;
        chk("A.hold.Q", 32'(ifa.Q), 32'd3);
        @(negedge C);
        ra = 1'b1;
        @(posedge C); #1;
        chk("A.resume.Q", 32'(ifa.Q), 32'd4);

        // Reset clears a pending overflow pulse.
        run_a(mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 4'd9, 1'b0, 1'b1), "A.pre9");
        run_a(mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0), "A.wrap");
        #2;
        ra = 1'b0;
        #1;
        chk("A.pend.OVF", 32'(ifa.OVF), 32'd0);
        chk("A.pend.Q",   32'(ifa.Q),   32'd3);

        @(negedge C);
        rb = 1'b1;
        for (int i = 0; i < 9; i++) run_b(tb[i], $sformatf("B[%0d]", i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tc_counter_reg.md
Name: tc_counter_reg

Overview:
- Parametrised loadable up/down counter-register built on the techlib DFF/DFFE and FA primitives; the successor to the single-bit DFFE cell.
- Replaces ad-hoc DFFE+FA chains that synthesis currently emits for counters, program counters and tick timers in Turing Complete builds.
- Adds a modulus, a configurable step, wrap/saturate modes, a terminal-count flag and an overflow pulse.

Parameters:
- W, 8, counter/data width in bits (1..32).
- MOD, 0, count modulus; legal range is 0..MOD-1; 0 means 2^W (natural binary wrap).
- STEP, 1, increment/decrement magnitude; 1 <= STEP < effective modulus.
- SAT, 0, 0 = wrap at range ends, 1 = saturate (clamp) at range ends.
- RST_VAL, 0, value of Q after reset; must be < effective modulus.

Ports:
- C, input, 1, clock; all state updates on the rising edge.
- R, input, 1, reset, asynchronous, active-low.
- CLR, input, 1, synchronous clear of Q to 0.
- LD, input, 1, synchronous parallel load of D.
- EN, input, 1, count enable.
- UP, input, 1, direction: 1 = count up, 0 = count down.
- D, input, W, load data.
- Q, output, W, registered count value.
- TC, output, 1, terminal count (combinational from Q and UP).
- OVF, output, 1, registered one-cycle pulse on a wrap or clamp event.

Behaviour:
- Effective modulus M = (MOD==0) ? 2^W : MOD. Legal values are 0..M-1. MAXV = M-1.
- Reset (R low, asynchronous, independent of C): Q = RST_VAL, OVF = 0. Q holds while R is low. The first update happens on the first rising C edge after R goes high.
- Per rising edge, priority is CLR > LD > EN. With none asserted, Q holds and OVF = 0.
- CLR: Q <= 0, OVF <= 0. Ignores LD, EN and UP.
- LD: Q <= (D > MAXV) ? MAXV : D, OVF <= 0. An out-of-range load is clamped and never raises OVF.
- EN, up, wrap (SAT=0):
  - if Q+STEP <= MAXV: Q <= Q+STEP, OVF <= 0.
  - otherwise: Q <= Q+STEP-M, OVF <= 1.
- EN, down, wrap (SAT=0):
  - if Q >= STEP: Q <= Q-STEP, OVF <= 0.
  - otherwise: Q <= Q-STEP+M, OVF <= 1.
- EN with SAT=1:
  - up: result clamps to MAXV; down: result clamps to 0.
  - OVF <= 1 only if clamping changed the result, or if Q was already at the limit in the count direction (blocked count).
- Arithmetic is carried out at W+1 bits so the carry/borrow is visible. No intermediate overflow is permitted for any legal parameter set.
- TC = UP ? (Q==MAXV) : (Q==0). It is purely combinational, with no latency and no gating by EN.
- Latency: Q and OVF change one edge after the controlling inputs are sampled. OVF is high for exactly one cycle per event; back-to-back events keep it high on consecutive cycles.
- A change of UP takes effect on the same edge it is sampled with.
- Reset asserted mid-count overrides everything immediately. A pending OVF is cleared.
- Q must never hold a value >= M in any reachable state.

Decomposition:
- Shared package tc_pkg holds:
  - mode constants MODE_WRAP = 0 and MODE_SAT = 1.
  - function eff_mod(W, MOD) returning M.
  - elaboration-time checks for STEP, RST_VAL and W ranges.
- Sub-module tc_addsub (W+1 bits, ripple of FA cells with XOR-inverted B for subtract) computes Q±STEP and the carry/borrow.
- The modulus correction and clamp muxes, plus the state register, stay in tc_counter_reg.

Test Plan:
- W=4, MOD=10, STEP=1, SAT=0, RST_VAL=3; R low then high, EN=1, UP=1 for 8 cycles -> Q sequence 3,4,...,9,0,1. OVF high only on the 9->0 edge. TC high while Q=9.
- Same configuration, UP=0 from Q=1, EN=1 for 3 cycles -> Q 1,0,9,8. OVF pulse on the 0->9 edge. TC high while Q=0.
- W=4, MOD=0, STEP=3, SAT=1; load 14, then UP=1 and EN=1 for 2 cycles -> Q 14,15,15, with OVF=1 on both edges. Then UP=0 from load 2 -> Q 2,0, OVF=1.
- W=4, MOD=10: LD=1 with D=13 -> Q=9, OVF=0. Assert CLR, LD and EN together -> Q=0.
- Mid-count (Q=6, EN=1), pull R low between edges -> Q=RST_VAL and OVF=0 immediately, without waiting for C. Release R -> counting resumes from RST_VAL on the next edge.
- EN=0 with UP toggling for 5 cycles -> Q unchanged and OVF=0, while TC follows UP combinationally for the current Q.
